// File: rtl/hl_rstseq_pkg.sv
// hl_rstseq_pkg
//  Shared definitions for the Hermes Lite reset sequencer.
//  State encodings are visible on the status register, so the numeric
//  values are fixed.
package hl_rstseq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_HOLD     = 3'd0,
      ST_LOCKWAIT = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAULT    = 3'd4
   } rstseq_state_e;

endpackage

// File: rtl/hl_sync2.sv
// hl_sync2
//  Generic two-flop synchroniser with asynchronous active-low clear to 0.
// Ports
//  clk    in   destination clock
//  clr_n  in   asynchronous active-low clear
//  d      in   asynchronous input
//  q      out  synchronised output, two clk edges behind d
module hl_sync2 (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/hl_reset_sequencer.sv
// hl_reset_sequencer
//  Power-on and recovery reset sequencer for the Hermes Lite core. Filters the
//  IF PLL lock, then releases NSTAGE active-low reset domains in order, spaced
//  STAGE_DLY cycles apart. Loss of lock, a software request or (optionally) a
//  watchdog expiry re-asserts every domain and restarts the sequence.
//  Optional feature macro: RSTSEQ_WDOG_EN (watchdog counter in RUN).
// Ports
//  rstclk       in   sequencer clock
//  extreset     in   asynchronous active-low reset
//  pll_locked   in   IF PLL lock, asynchronous
//  sw_rst       in   one-cycle re-sequence request
//  wdog_kick    in   watchdog kick pulse (ignored without RSTSEQ_WDOG_EN)
//  rst_n        out  per-domain active-low resets, bit 0 released first
//  seq_done     out  high while every domain is released
//  state        out  current FSM state
//  restart_cnt  out  saturating count of fault restarts
//
// state    | meaning
// HOLD     | one cycle after reset, all domains held
// LOCKWAIT | counting consecutive synchronised lock cycles
// RELEASE  | releasing domains one by one, STAGE_DLY apart
// RUN      | all domains released, watching for restart events
// FAULT    | one cycle with all domains re-asserted, then LOCKWAIT
module hl_reset_sequencer
   import hl_rstseq_pkg::*;
#(
   parameter int NSTAGE    = 4,
   parameter int STAGE_DLY = 4096,
   parameter int LOCK_FILT = 1024,
   parameter int CW        = 8,
   parameter int WDOG_CYC  = 65536
) (
   input  logic               rstclk,
   input  logic               extreset,
   input  logic               pll_locked,
   input  logic               sw_rst,
   input  logic               wdog_kick,
   output logic [NSTAGE-1:0]  rst_n,
   output logic               seq_done,
   output logic [STATE_W-1:0] state,
   output logic [CW-1:0]      restart_cnt
);

   localparam int FW = $clog2(LOCK_FILT + 1);
   localparam int DW = $clog2(STAGE_DLY + 1);
   localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   logic lock_s;

   hl_sync2 u_lock_sync (
      .clk   (rstclk),
      .clr_n (extreset),
      .d     (pll_locked),
      .q     (lock_s)
   );

   rstseq_state_e     state_q, state_d;
   logic [NSTAGE-1:0] rst_n_q, rst_n_d;
   logic              seq_done_q, seq_done_d;
   logic [CW-1:0]     restart_q, restart_d;
   logic [FW-1:0]     filt_q, filt_d;
   logic [DW-1:0]     dly_q, dly_d;
   logic [SW-1:0]     stage_q, stage_d;
   logic              wdog_fault;
   logic              restart_evt;
   logic              counted_evt;

`ifdef RSTSEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog_q, wdog_d;

   assign wdog_fault = (state_q == ST_RUN) && (wdog_q == WW'(WDOG_CYC));

   always_ff @(posedge rstclk or negedge extreset) begin
      if (!extreset) wdog_q <= '0;
      else           wdog_q <= wdog_d;
   end
`else
   logic unused_wdog;
   assign unused_wdog = wdog_kick ^ (WDOG_CYC == 0);
   assign wdog_fault  = 1'b0;
`endif

   // sw_rst alone restarts without counting; any lock or watchdog fault in
   // the same cycle makes it a single counted fault.
   assign restart_evt = ~lock_s | sw_rst | wdog_fault;
   assign counted_evt = ~lock_s | wdog_fault;

   always_comb begin
      state_d    = state_q;
      rst_n_d    = rst_n_q;
      seq_done_d = seq_done_q;
      restart_d  = restart_q;
      filt_d     = filt_q;
      dly_d      = dly_q;
      stage_d    = stage_q;
`ifdef RSTSEQ_WDOG_EN
      wdog_d     = wdog_q;
`endif
      case (state_q)
         ST_HOLD: begin
            state_d = ST_LOCKWAIT;
            filt_d  = '0;
         end
         ST_LOCKWAIT: begin
            if (filt_q == FW'(LOCK_FILT)) begin
               state_d = ST_RELEASE;
               stage_d = '0;
               dly_d   = '0;
            end else if (lock_s) begin
               filt_d = filt_q + 1'b1;
            end else begin
               filt_d = '0;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (restart_evt) begin
               state_d    = ST_FAULT;
               rst_n_d    = '0;
               seq_done_d = 1'b0;
               if (counted_evt && (restart_q != {CW{1'b1}}))
                  restart_d = restart_q + 1'b1;
            end else if (state_q == ST_RELEASE) begin
               // dly_q counts 0..STAGE_DLY-1, so each release lands exactly
               // STAGE_DLY edges after the previous one.
               if (dly_q == DW'(STAGE_DLY - 1)) begin
                  rst_n_d[stage_q] = 1'b1;
                  dly_d            = '0;
                  if (stage_q == SW'(NSTAGE - 1)) begin
                     state_d    = ST_RUN;
                     seq_done_d = 1'b1;
`ifdef RSTSEQ_WDOG_EN
                     wdog_d     = '0;
`endif
                  end else begin
                     stage_d = stage_q + 1'b1;
                  end
               end else begin
                  dly_d = dly_q + 1'b1;
               end
            end else begin
`ifdef RSTSEQ_WDOG_EN
               wdog_d = wdog_kick ? '0 : wdog_q + 1'b1;
`endif
            end
         end
         ST_FAULT: begin
            state_d = ST_LOCKWAIT;
            filt_d  = '0;
         end
         default: begin
            state_d    = ST_HOLD;
            rst_n_d    = '0;
            seq_done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge rstclk or negedge extreset) begin
      if (!extreset) begin
         state_q    <= ST_HOLD;
         rst_n_q    <= '0;
         seq_done_q <= 1'b0;
         restart_q  <= '0;
         filt_q     <= '0;
         dly_q      <= '0;
         stage_q    <= '0;
      end else begin
         state_q    <= state_d;
         rst_n_q    <= rst_n_d;
         seq_done_q <= seq_done_d;
         restart_q  <= restart_d;
         filt_q     <= filt_d;
         dly_q      <= dly_d;
         stage_q    <= stage_d;
      end
   end

   assign rst_n       = rst_n_q;
   assign seq_done    = seq_done_q;
   assign state       = state_q;
   assign restart_cnt = restart_q;

endmodule

// File: tb/tb_hl_reset_sequencer.sv
module tb_hl_reset_sequencer;

   localparam int S_HOLD = 0, S_LOCKWAIT = 1, S_RELEASE = 2, S_RUN = 3, S_FAULT = 4;

   logic       rstclk = 1'b0;
   logic       extreset = 1'b1;
   logic       pll_locked = 1'b1;
   logic       sw_rst = 1'b0;
   logic       wdog_kick = 1'b0;
   logic [2:0] rst_n_o;
   logic       seq_done;
   logic [2:0] state;
   logic [7:0] restart_cnt;

   int errors = 0;
   int checks = 0;
   int edge_cnt;
   int base_cnt;

   always #5 rstclk = ~rstclk;

   hl_reset_sequencer #(
      .NSTAGE(3), .STAGE_DLY(4), .LOCK_FILT(8), .CW(8), .WDOG_CYC(16)
   ) dut (
      .rstclk      (rstclk),
      .extreset    (extreset),
      .pll_locked  (pll_locked),
      .sw_rst      (sw_rst),
      .wdog_kick   (wdog_kick),
      .rst_n       (rst_n_o),
      .seq_done    (seq_done),
      .state       (state),
      .restart_cnt (restart_cnt)
   );

   typedef struct {
      int         edge_n;
      logic [2:0] rst;
      logic       done;
      logic [2:0] st;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge rstclk);
         #1;
         edge_cnt++;
      end
   endtask

   task automatic wait_state(input int target, input int budget, input string name);
      int n = 0;
      do begin
         step(1);
         n++;
      end while (state != 3'(target) && n < budget);
      checks++;
      if (state != 3'(target)) begin
         errors++;
         $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, state, n, target);
      end
   endtask

   task automatic do_reset(input logic lock);
      pll_locked = lock;
      sw_rst     = 1'b0;
      wdog_kick  = 1'b0;
      #2 extreset = 1'b0;
      step(2);
      extreset = 1'b1;
      edge_cnt = 0;
   endtask

   initial begin
      vecs[0] = '{1,  3'b000, 1'b0, 3'(S_LOCKWAIT)};
      vecs[1] = '{10, 3'b000, 1'b0, 3'(S_LOCKWAIT)};
      vecs[2] = '{11, 3'b000, 1'b0, 3'(S_RELEASE)};
      vecs[3] = '{14, 3'b000, 1'b0, 3'(S_RELEASE)};
      vecs[4] = '{15, 3'b001, 1'b0, 3'(S_RELEASE)};
      vecs[5] = '{18, 3'b001, 1'b0, 3'(S_RELEASE)};
      vecs[6] = '{19, 3'b011, 1'b0, 3'(S_RELEASE)};
      vecs[7] = '{22, 3'b011, 1'b0, 3'(S_RELEASE)};
      vecs[8] = '{23, 3'b111, 1'b1, 3'(S_RUN)};
      vecs[9] = '{30, 3'b111, 1'b1, 3'(S_RUN)};

      // reset values, sampled while extreset is held low
      pll_locked = 1'b1;
      #2 extreset = 1'b0;
      step(3);
      chk("rst_rst_n", rst_n_o, 0);
      chk("rst_done", seq_done, 0);
      chk("rst_state", state, S_HOLD);
      chk("rst_restart", restart_cnt, 0);

      // power-on sequence with lock steady
      extreset = 1'b1;
      edge_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         while (edge_cnt < vecs[i].edge_n) step(1);
         chk($sformatf("pwr_rst_n@%0d", vecs[i].edge_n), rst_n_o, vecs[i].rst);
         chk($sformatf("pwr_done@%0d", vecs[i].edge_n), seq_done, vecs[i].done);
         chk($sformatf("pwr_state@%0d", vecs[i].edge_n), state, vecs[i].st);
      end

      // lock filter: 5 high, 3 low, then high
      do_reset(1'b0);
      step(6);
      chk("filt_idle", state, S_LOCKWAIT);
      pll_locked = 1'b1;
      base_cnt = edge_cnt;
      sw_rst = 1'b1;
      step(1);
      sw_rst = 1'b0;
      chk("sw_rst_lockwait_ignored", state, S_LOCKWAIT);
      step(4);
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(base_cnt + 11 - edge_cnt);
      chk("filt_no_early_release", state, S_LOCKWAIT);
      step(base_cnt + 18 - edge_cnt);
      chk("filt_still_wait", state, S_LOCKWAIT);
      step(1);
      chk("filt_release", state, S_RELEASE);
      wait_state(S_RUN, 20, "filt_to_run");

      // lock loss in RUN: three edges to rst_n=0
      pll_locked = 1'b0;
      step(2);
      chk("lockloss_rst_n_e2", rst_n_o, 7);
      step(1);
      chk("lockloss_rst_n_e3", rst_n_o, 0);
      chk("lockloss_state", state, S_FAULT);
      chk("lockloss_done", seq_done, 0);
      chk("lockloss_restart", restart_cnt, 1);
      step(1);
      chk("lockloss_lockwait", state, S_LOCKWAIT);
      pll_locked = 1'b1;
      wait_state(S_RUN, 40, "lockloss_resequence");
      chk("lockloss_reseq_rst_n", rst_n_o, 7);
      chk("lockloss_reseq_done", seq_done, 1);

      // sw_rst and lock loss seen on the same edge: one increment
      pll_locked = 1'b0;
      step(2);
      sw_rst = 1'b1;
      step(1);
      sw_rst = 1'b0;
      chk("both_state", state, S_FAULT);
      chk("both_restart", restart_cnt, 2);
      step(3);
      pll_locked = 1'b1;
      wait_state(S_RUN, 40, "both_resequence");
      chk("both_restart_after", restart_cnt, 2);

      // sw_rst alone: re-sequence without counting
      sw_rst = 1'b1;
      step(1);
      sw_rst = 1'b0;
      chk("sw_state", state, S_FAULT);
      chk("sw_rst_n", rst_n_o, 0);
      chk("sw_restart", restart_cnt, 2);
      wait_state(S_RUN, 40, "sw_resequence");
      chk("sw_restart_after", restart_cnt, 2);

      // watchdog: kicks every 10 cycles, then stop kicking
      for (int k = 0; k < 5; k++) begin
         step(9);
         wdog_kick = 1'b1;
         step(1);
         wdog_kick = 1'b0;
      end
      chk("wdog_kicked_run", state, S_RUN);
`ifdef RSTSEQ_WDOG_EN
      wait_state(S_FAULT, 25, "wdog_expire");
      chk("wdog_restart", restart_cnt, 3);
      wait_state(S_RUN, 40, "wdog_resequence");
`else
      step(30);
      chk("nowdog_stays_run", state, S_RUN);
      chk("nowdog_restart", restart_cnt, 2);
`endif

      // async reset in the middle of RUN takes effect without a clock edge
      @(negedge rstclk);
      extreset = 1'b0;
      #1;
      chk("async_rst_n", rst_n_o, 0);
      chk("async_state", state, S_HOLD);
      chk("async_restart", restart_cnt, 0);
      chk("async_done", seq_done, 0);
      step(1);
      extreset = 1'b1;
      step(1);
      chk("async_restart_hold", state, S_LOCKWAIT);
      wait_state(S_RUN, 40, "async_resequence");

      // saturation of restart_cnt
      for (int t = 1; t <= 260; t++) begin
         pll_locked = 1'b0;
         wait_state(S_FAULT, 6, "sat_fault");
         pll_locked = 1'b1;
         wait_state(S_RUN, 40, "sat_run");
         if (t == 100) chk("sat_mid", restart_cnt, 100);
         if (t == 255) chk("sat_255", restart_cnt, 255);
      end
      chk("sat_final", restart_cnt, 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
